// File: rtl/seq_mul_pkg.sv
// Shared constants for the iterative shift-add multiplier: FSM state
// encoding and the supported operand width range.
package seq_mul_pkg;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      BUSY = S_BUSY,
      DONE = S_DONE
   } state_e;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, unsigned or two's-complement per operation,
// one multiplier bit per cycle, with valid/ready on both sides.
module seq_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("seq_multiplier: WIDTH outside supported range");
   end

   state_e          state_r;
   logic [PW-1:0]   acc_r;
   logic [PW-1:0]   mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [CW-1:0]   cnt_r;
   logic            neg_r;

   logic [PW-1:0]   addend_s;
   logic [PW-1:0]   acc_nxt_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;

   // Most-negative value negates to itself, which is its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn & v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   // Operand magnitudes and the accumulator value after this cycle's partial product.
   always_comb begin
      a_mag_s   = magnitude(a, signed_mode);
      b_mag_s   = magnitude(b, signed_mode);
      addend_s  = '0;
      if (mplier_r[0]) begin
         addend_s = mcand_r;
      end else begin
         addend_s = '0;
      end
      acc_nxt_s = acc_r + addend_s;
   end

   // Control FSM and datapath; handshake flags are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         acc_r     <= '0;
         mcand_r   <= '0;
         mplier_r  <= '0;
         cnt_r     <= '0;
         neg_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
                  mplier_r <= b_mag_s;
                  neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_r    <= '0;
                  cnt_r    <= CW'(WIDTH - 1);
                  in_ready <= 1'b0;
                  state_r  <= BUSY;
               end
            end
            BUSY: begin
               acc_r    <= acc_nxt_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r - CW'(1);
               if (cnt_r == '0) begin
                  out       <= neg_r ? (~acc_nxt_s + PW'(1)) : acc_nxt_s;
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a WIDTH=2 instance for exhaustive checks
// and a WIDTH=8 instance for corner values, backpressure, reset and throughput.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst;

   logic       iv2, ir2, ov2, or2, sm2;
   logic [1:0] a2, b2;
   logic [3:0] out2;

   logic        iv8, ir8, ov8, or8, sm8;
   logic [7:0]  a8, b8;
   logic [15:0] out8;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int acc_q[$];
   logic [15:0] res_q[$];

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] exp;
   } vec8_t;

   vec8_t vt[10];

   seq_multiplier #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
      .signed_mode(sm2), .out_valid(ov2), .out_ready(or2), .out(out2)
   );

   seq_multiplier #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .out(out8)
   );

   always #5 clk = ~clk;

   // Cycle count, accept timestamps, delivered results and flag exclusivity.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (iv8 && ir8) acc_q.push_back(cyc);
      if (ov8 && or8) res_q.push_back(out8);
      if ((ov8 && ir8) || (ov2 && ir2)) begin
         err_cnt <= err_cnt + 1;
         $display("FAIL flag_excl: out_valid and in_ready both high at cycle %0d", cyc);
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [15:0] exp, input string nm);
      int n;
      n = 0;
      while (!(w8 ? ir8 : ir2) && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check({nm, "_rdy"}, w8 ? ir8 : ir2, 1);
      if (w8) begin
         a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1; or8 = 1'b1;
      end else begin
         a2 = a[1:0]; b2 = b[1:0]; sm2 = sm; iv2 = 1'b1; or2 = 1'b1;
      end
      @(posedge clk); #1;
      iv8 = 1'b0;
      iv2 = 1'b0;
      n = 0;
      while (!(w8 ? ov8 : ov2) && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check({nm, "_lat"}, n, w8 ? 8 : 2);
      check(nm, w8 ? {48'd0, out8} : {60'd0, out2}, {48'd0, exp});
   endtask

   initial begin
      int n;
      logic [15:0] e;
      logic [15:0] b2b_exp[4];

      vt[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vt[1] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
      vt[2] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vt[3] = '{8'h07, 8'h09, 1'b0, 16'h003F};
      vt[4] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
      vt[5] = '{8'h00, 8'hFF, 1'b0, 16'h0000};
      vt[6] = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
      vt[7] = '{8'h80, 8'h02, 1'b0, 16'h0100};
      vt[8] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
      vt[9] = '{8'h0C, 8'h0A, 1'b0, 16'h0078};

      rst = 1'b1;
      iv2 = 1'b0; or2 = 1'b1; sm2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
      iv8 = 1'b0; or8 = 1'b1; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready8", ir8, 1);
      check("rst_out_valid8", ov8, 0);
      check("rst_out8", out8, 0);
      check("rst_in_ready2", ir2, 1);
      check("rst_out2", out2, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(1'b0, 8'd2, 8'd3, 1'b0, 16'd6, "w2_u_2x3");
      do_op(1'b0, 8'd2, 8'd2, 1'b1, 16'h0004, "w2_s_m2xm2");
      for (int sm = 0; sm < 2; sm++) begin
         for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
               int sa;
               int sb;
               sa = (sm == 1 && ai >= 2) ? ai - 4 : ai;
               sb = (sm == 1 && bi >= 2) ? bi - 4 : bi;
               e = 16'((sa * sb) & 15);
               do_op(1'b0, 8'(ai), 8'(bi), 1'(sm), e, "w2_exh");
            end
         end
      end

      for (int i = 0; i < 10; i++) begin
         do_op(1'b1, vt[i].a, vt[i].b, vt[i].sm, vt[i].exp, $sformatf("w8_vec%0d", i));
      end

      // Backpressure with stray operands during BUSY and DONE.
      @(posedge clk); #1;
      res_q.delete();
      acc_q.delete();
      or8 = 1'b0;
      a8 = 8'h0C; b8 = 8'h0A; sm8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      a8 = 8'h55; b8 = 8'h33; iv8 = 1'b1;
      check("bp_busy_ready", ir8, 0);
      @(posedge clk); #1;
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check("bp_valid", ov8, 1);
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_out", out8, 16'h0078);
         check("bp_hold_ready", ir8, 0);
         iv8 = (k == 2);
         a8 = 8'h11;
         @(posedge clk); #1;
      end
      iv8 = 1'b0;
      check("bp_still_valid", ov8, 1);
      or8 = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", ov8, 0);
      check("bp_ready_back", ir8, 1);
      repeat (3) @(posedge clk);
      #1;
      check("bp_one_result", res_q.size(), 1);
      check("bp_result", (res_q.size() > 0) ? res_q[0] : 16'hDEAD, 16'h0078);
      check("bp_one_accept", acc_q.size(), 1);
      check("bp_out_kept", out8, 16'h0078);

      // Reset three cycles into BUSY discards the product.
      res_q.delete();
      a8 = 8'h33; b8 = 8'h44; sm8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_ready", ir8, 1);
      check("rst_mid_valid", ov8, 0);
      check("rst_mid_out", out8, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("rst_mid_no_result", res_q.size(), 0);
      check("rst_mid_valid_late", ov8, 0);
      do_op(1'b1, 8'd7, 8'd9, 1'b0, 16'd63, "rst_then_7x9");

      // Back-to-back issue with out_ready held high.
      @(posedge clk); #1;
      res_q.delete();
      acc_q.delete();
      b2b_exp[0] = 16'h000C;
      b2b_exp[1] = 16'hFFFE;
      b2b_exp[2] = 16'h0100;
      b2b_exp[3] = 16'hC0FF;
      do_op(1'b1, 8'h03, 8'h04, 1'b0, b2b_exp[0], "b2b0");
      do_op(1'b1, 8'hFF, 8'h02, 1'b1, b2b_exp[1], "b2b1");
      do_op(1'b1, 8'h10, 8'h10, 1'b0, b2b_exp[2], "b2b2");
      do_op(1'b1, 8'h81, 8'h7F, 1'b1, b2b_exp[3], "b2b3");
      @(posedge clk); #1;
      check("b2b_accepts", acc_q.size(), 4);
      check("b2b_results", res_q.size(), 4);
      for (int k = 0; k < 3; k++) begin
         if (acc_q.size() == 4) check($sformatf("b2b_interval%0d", k), acc_q[k+1] - acc_q[k], 10);
      end
      for (int k = 0; k < 4; k++) begin
         if (res_q.size() == 4) check($sformatf("b2b_order%0d", k), res_q[k], b2b_exp[k]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative, parametrised shift-add multiplier for `WIDTH`-bit operands, producing a `2*WIDTH`-bit product. It supports unsigned and two's-complement signed modes, selected per operation. It replaces the single-cycle combinational multiplier wherever area matters more than latency. Operands and results move over valid/ready handshakes so the block can sit between the UART datapath stages.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: operand pair and mode are valid.
- `in_ready`, output, 1: block accepts operands; high only in IDLE.
- `a`, input, `WIDTH`: multiplicand.
- `b`, input, `WIDTH`: multiplier.
- `signed_mode`, input, 1: 1 means `a` and `b` are two's complement; 0 means unsigned.
- `out_valid`, output, 1: `out` holds a finished product.
- `out_ready`, input, 1: consumer takes the product.
- `out`, output, `2*WIDTH`: product, signed or unsigned per the latched mode.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready=1`.
  - On an edge with `in_valid`:
    - Latch the magnitudes of `a` and `b`. In signed mode a negative operand is negated; its magnitude fits in `WIDTH` unsigned bits, including the most-negative value.
    - Latch the result sign `neg = signed_mode & (a[MSB] ^ b[MSB])`.
    - Clear the accumulator; load the bit counter with `WIDTH-1`; go to BUSY.
- **BUSY**
  - Each edge: if the multiplier LSB is 1, add the shifted multiplicand to the `2*WIDTH`-bit accumulator.
  - Then shift the multiplicand left and the multiplier right, and decrement the counter.
  - On the edge where the counter is 0, write `out` with the accumulator, two's-complement negated if `neg`, and go to DONE.
- **DONE**
  - `out_valid=1`; `out` is stable.
  - On an edge with `out_ready`, go to IDLE and drop `out_valid`.
  - `out` keeps its last value after the handshake.
- **Width rules**
  - Unsigned results are exact in `2*WIDTH` bits.
  - Signed results are exact in `2*WIDTH` bits, two's complement. For WIDTH=8, (-128)*(-128) = 16384 = 0x4000.
- **Boundary conditions**
  - `in_valid` outside IDLE is ignored; inputs need not be held stable.
  - A zero operand still takes the full `WIDTH` cycles; there is no early termination.
  - Asserting `rst` in any state forces IDLE immediately. Any in-flight product is discarded and no `out_valid` is produced for it.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready=1`, `out_valid=0`, `out=0`.
  - Accumulator and counter 0.
- Latency: with accept on edge T, `out_valid` rises after edge T+`WIDTH`.
- Minimum issue interval: `WIDTH+2` cycles. This comes from one IDLE cycle, `WIDTH` BUSY cycles and one DONE cycle when `out_ready` is held high.
- `in_ready` and `out_valid` are decoded from registered state only; there are no combinational paths from input to output.
- `out_valid` and `in_ready` are never high in the same cycle.

## Structure
- Package `seq_mul_pkg` holds:
  - the FSM state encoding (2-bit localparams `S_IDLE`, `S_BUSY`, `S_DONE`);
  - the `WIDTH` range-check constants.
- No sub-module: datapath and FSM live in one module. Counter width is `$clog2(WIDTH)`.

## Test plan
- WIDTH=2, unsigned, `a=2'b10`, `b=2'b11` -> `out=4'd6`, `out_valid` rising 2 edges after accept.
- WIDTH=2, exhaustive over all 16 pairs in both modes, `out_ready` held high -> every product matches the reference model; signed (-2)*(-2)=4'b0100.
- WIDTH=8, signed:
  - `a=8'h80`, `b=8'h80` -> `out=16'h4000`.
  - `a=8'hFF`, `b=8'h01` -> `out=16'hFFFF`.
  - unsigned `a=8'hFF`, `b=8'hFF` -> `out=16'hFE01`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid`, and pulse `in_valid` during BUSY and DONE -> `out` stable, `in_ready=0`, extra operands ignored, exactly one result.
- Reset mid-BUSY (WIDTH=8, 3 cycles after accept) -> immediately IDLE, `out=0`, `out_valid=0`. The next operation 7*9 returns 63.
- Back-to-back: issue 4 operations with `out_ready=1` -> issue interval exactly `WIDTH+2` cycles, results in order.
